// File: rtl/data_memory_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester IDs and the
// captured request record.
package data_memory_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_CORE   = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

  typedef struct packed {
    logic              owner;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/round_robin_arbiter2.sv
// Two-way round-robin arbiter: a one-hot grant, with last_grant moved on every
// advance so the other port wins the next tie.
module round_robin_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

  // Resetting to 1 hands port 0 the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (advance && (|grant)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares one single-port data memory between the core LSU (port 0) and the
// loader (port 1): accept, one ACCESS cycle, then a one-cycle response.
module data_memory_arbiter
  import data_memory_pkg::*;
#(
  parameter int unsigned WORD_NUM = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_write,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_t            state;
  mem_req_t          req_p1;
  logic [1:0]        grant;
  logic              accept;
  logic [1:0]        resp_valid_p2;
  logic              resp_error_p2;
  logic [DATA_W-1:0] resp_rdata_p2;

  // Unsigned 32-bit compare, so 0xFFFFFFFF is out of range rather than negative.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(WORD_NUM);
  endfunction

  function automatic logic [DATA_W-1:0] read_result(input logic write,
                                                    input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] rdata);
    return (!write && in_range(addr)) ? rdata : '0;
  endfunction

  assign accept = (state == IDLE) && (|req_valid) && !reset;

  round_robin_arbiter2 u_arbiter (
    .clock   (clock),
    .reset   (reset),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign req_ready = accept ? grant : 2'b00;

  // Memory pins are live only in ACCESS; reset in that cycle suppresses the write.
  always_comb begin
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    if ((state == ACCESS) && !reset) begin
      mem_write_enable = req_p1.write && in_range(req_p1.addr);
      mem_address      = req_p1.addr;
      mem_write_data   = req_p1.wdata;
    end
  end

  assign resp_valid = resp_valid_p2 & {2{!reset}};
  assign resp_rdata = resp_rdata_p2;
  assign resp_error = resp_error_p2;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      resp_valid_p2 <= 2'b00;
      resp_error_p2 <= 1'b0;
      resp_rdata_p2 <= '0;
    end else begin
      unique case (state)
        // IDLE -> ACCESS: capture the winner's request into req_p1
        IDLE: begin
          resp_valid_p2 <= 2'b00;
          if (accept) begin
            req_p1.owner <= grant[1];
            req_p1.write <= req_write[grant[1]];
            req_p1.addr  <= grant[1] ? req_addr1  : req_addr0;
            req_p1.wdata <= grant[1] ? req_wdata1 : req_wdata0;
            state        <= ACCESS;
          end
        end
        // ACCESS -> RESP: register the memory result into the _p2 response stage
        ACCESS: begin
          resp_valid_p2 <= (req_p1.owner == PORT_LOADER) ? 2'b10 : 2'b01;
          resp_error_p2 <= !in_range(req_p1.addr);
          resp_rdata_p2 <= read_result(req_p1.write, req_p1.addr, mem_read_data);
          state         <= RESP;
        end
        RESP: begin
          resp_valid_p2 <= 2'b00;
          state         <= IDLE;
        end
        default: begin
          resp_valid_p2 <= 2'b00;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Randomized bench for data_memory_arbiter against a transaction-level model
// (timing t/t+1/t+2, round-robin winner, shadow memory contents).
module tb_data_memory_arbiter;

  localparam int          WORD_NUM = 1024;
  localparam logic [31:0] WN       = 32'd1024;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_write, resp_valid;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
  logic        resp_error, mem_write_enable;

  logic [31:0] mem     [WORD_NUM];
  logic [31:0] ref_mem [WORD_NUM];

  always #5 clock = ~clock;

  assign mem_read_data = (mem_address < WN) ? mem[mem_address[9:0]] : 32'h0;

  data_memory_arbiter #(.WORD_NUM(WORD_NUM)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr0        (req_addr0),
    .req_addr1        (req_addr1),
    .req_wdata0       (req_wdata0),
    .req_wdata1       (req_wdata1),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = -100;
  int mdl_last = 1;
  int refill_pct = 0;

  logic        fl_owner, fl_write, exp_err;
  logic [31:0] fl_addr, fl_wdata, exp_rdata;

  logic        pend [2];
  logic        pw   [2];
  logic [31:0] pa   [2];
  logic [31:0] pd   [2];
  logic        refill [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    pend[p] = 1'b1;
    pw[p]   = w;
    pa[p]   = a;
    pd[p]   = d;
  endtask

  task automatic gen(input int p);
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = 32'd1000 + 32'($urandom_range(0, 60));
      1:       a = $urandom;
      default: a = 32'($urandom_range(0, 15));
    endcase
    issue(p, 1'($urandom_range(0, 1)), a, $urandom);
  endtask

  // One clock: drive at posedge+1, predict and compare at negedge.
  task automatic step();
    logic [1:0]  exp_ready, exp_rv;
    logic        exp_we;
    logic [31:0] exp_addr, exp_wd;
    int          d, w;
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = pend[p];
      req_write[p] = pend[p] ? pw[p] : 1'($urandom_range(0, 1));
    end
    req_addr0  = pend[0] ? pa[0] : $urandom;
    req_addr1  = pend[1] ? pa[1] : $urandom;
    req_wdata0 = pend[0] ? pd[0] : $urandom;
    req_wdata1 = pend[1] ? pd[1] : $urandom;
    @(negedge clock);
    exp_ready = 2'b00;
    exp_rv    = 2'b00;
    exp_we    = 1'b0;
    exp_addr  = 32'h0;
    exp_wd    = 32'h0;
    if (reset) begin
      last_acc = -100;
      mdl_last = 1;
    end else begin
      d = cyc - last_acc;
      if (d == 1) begin
        exp_addr  = fl_addr;
        exp_wd    = fl_wdata;
        exp_we    = fl_write && (fl_addr < WN);
        exp_err   = !(fl_addr < WN);
        exp_rdata = (!fl_write && (fl_addr < WN)) ? ref_mem[fl_addr[9:0]] : 32'h0;
        if (exp_we) ref_mem[fl_addr[9:0]] = fl_wdata;
      end
      if (d == 2) exp_rv[fl_owner] = 1'b1;
      if (d >= 3 && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) w = 1 - mdl_last;
        else                    w = pend[1] ? 1 : 0;
        exp_ready[w] = 1'b1;
        mdl_last = w;
        last_acc = cyc;
        fl_owner = w[0];
        fl_write = pw[w];
        fl_addr  = pa[w];
        fl_wdata = pd[w];
      end
    end
    check("req_ready",  32'(req_ready),        32'(exp_ready));
    check("resp_valid", 32'(resp_valid),       32'(exp_rv));
    check("mem_we",     32'(mem_write_enable), 32'(exp_we));
    check("mem_addr",   mem_address,           exp_addr);
    check("mem_wdata",  mem_write_data,        exp_wd);
    if (exp_rv != 2'b00) begin
      check("resp_rdata", resp_rdata,        exp_rdata);
      check("resp_error", 32'(resp_error),   32'(exp_err));
    end
    if (mem_write_enable && (mem_address < WN)) mem[mem_address[9:0]] = mem_write_data;
    for (int p = 0; p < 2; p++) begin
      if (req_ready[p]) pend[p] = 1'b0;
      if (!pend[p] && refill[p] && ($urandom_range(0, 99) < refill_pct)) gen(p);
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n, prev_acc;
    logic [31:0] v;
    for (int i = 0; i < WORD_NUM; i++) begin
      v = $urandom;
      mem[i]     = v;
      ref_mem[i] = v;
    end
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; pw[p] = 1'b0; pa[p] = 32'h0; pd[p] = 32'h0; refill[p] = 1'b0;
    end
    reset = 1'b1;

    // Reset held with both requests pending; then write/read of 0x10.
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF);
    issue(1, 1'b0, 32'h10, 32'h0);
    run(3);
    reset = 1'b0;
    run(8);

    // Continuous contention: strict alternation, accepts every 3 cycles.
    refill_pct = 100;
    refill[0] = 1'b1; refill[1] = 1'b1;
    gen(0); gen(1);
    run(18);
    refill[0] = 1'b0; refill[1] = 1'b0;
    run(10);

    // Out-of-range write must not alias onto word 0; out-of-range read.
    issue(1, 1'b1, WN, 32'h12345678);
    run(4);
    issue(0, 1'b0, 32'h0, 32'h0);
    run(4);
    issue(1, 1'b0, 32'hFFFF_FFFF, 32'h0);
    run(4);
    issue(0, 1'b0, 32'd1023, 32'h0);
    run(4);

    // Reset landing on the ACCESS cycle of a write to addr 5.
    issue(0, 1'b1, 32'd5, ~ref_mem[5]);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    issue(0, 1'b0, 32'd5, 32'h0);
    run(4);

    // Port 1 streaming reads back to back.
    prev_acc = 0;
    for (int k = 0; k < 4; k++) begin
      issue(1, 1'b0, 32'($urandom_range(0, 15)), 32'h0);
      n = 0;
      while (pend[1] && n < 10) begin
        step();
        n++;
      end
      check("stream_accepted", 32'(pend[1]), 32'h0);
      if (k > 0) check("stream_gap", 32'(cyc - 1 - prev_acc), 32'd3);
      prev_acc = cyc - 1;
    end
    run(4);

    // Random mixed traffic with occasional reset.
    refill_pct = 40;
    refill[0] = 1'b1; refill[1] = 1'b1;
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    refill[0] = 1'b0; refill[1] = 1'b0;
    run(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
